// File: rtl/bp_pkg.sv
// Shared encodings for the fetch-stage branch predictor.
// Counter states, sweep FSM states and the PC width.
package bp_pkg;

  localparam int BP_PC_W = 32;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_e;

  typedef enum logic {
    BP_ST_INIT  = 1'b0,
    BP_ST_READY = 1'b1
  } bp_state_e;

endpackage

// File: rtl/bp_sat_counter.sv
// 2-bit saturating counter next-state function.
// Taken counts up toward ST, not-taken down toward SNT.
module bp_sat_counter
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       taken,
  output logic [1:0] ctr_next
);

  // saturating step in the direction of the outcome
  always_comb begin
    ctr_next = ctr;
    if (taken) begin
      if (ctr != BP_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != BP_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Direct-mapped BTB with 2-bit counters and a valid-bit sweep FSM.
// Optional stat counters are built when BP_STATS_EN is defined.
module branch_target_predictor
  import bp_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [BP_PC_W-1:0]  fetch_pc,
  output logic                pred_taken,
  output logic [BP_PC_W-1:0]  pred_target,
  input  logic                upd_valid,
  input  logic [BP_PC_W-1:0]  upd_pc,
  input  logic                upd_taken,
  input  logic [BP_PC_W-1:0]  upd_target,
  input  logic                upd_pred_taken,
  input  logic                inv_req,
  output logic                ready
`ifdef BP_STATS_EN
  ,
  output logic [31:0]         stat_updates,
  output logic [31:0]         stat_mispredicts
`endif
);

  localparam int TAG_W = BP_PC_W - IDX_W - 2;

  bp_state_e          state_q, state_d;
  logic [IDX_W-1:0]   sweep_q, sweep_d;

  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q [ENTRIES];
  logic [BP_PC_W-1:0] tgt_q [ENTRIES];
  logic [1:0]         ctr_q [ENTRIES];

  logic [IDX_W-1:0]   f_idx, u_idx;
  logic [TAG_W-1:0]   f_tag, u_tag;
  logic               f_hit, u_hit;
  logic               upd_acc;
  logic               wr_en;
  logic [1:0]         ctr_nxt;

  assign ready = (state_q == BP_ST_READY);

  assign f_idx = fetch_pc[IDX_W+1:2];
  assign f_tag = fetch_pc[BP_PC_W-1:IDX_W+2];
  assign u_idx = upd_pc[IDX_W+1:2];
  assign u_tag = upd_pc[BP_PC_W-1:IDX_W+2];

  assign f_hit = ready & valid_q[f_idx]
               & (tag_q[f_idx] == f_tag);
  assign u_hit = valid_q[u_idx]
               & (tag_q[u_idx] == u_tag);

  assign pred_taken  = f_hit & ctr_q[f_idx][1];
  assign pred_target = pred_taken ? tgt_q[f_idx]
                                  : '0;

  // invalidate beats a same-cycle update
  assign upd_acc = upd_valid & ready & ~inv_req;
  assign wr_en   = upd_acc & (u_hit | upd_taken);

  bp_sat_counter u_ctr (
    .ctr      (ctr_q[u_idx]),
    .taken    (upd_taken),
    .ctr_next (ctr_nxt)
  );

  // sweep FSM state and index registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BP_ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // next sweep state: walk every index, restart on invalidate
  always_comb begin
    state_d = state_q;
    sweep_d = sweep_q;
    unique case (state_q)
      BP_ST_INIT: begin
        if (inv_req) begin
          sweep_d = '0;
        end else if (sweep_q == IDX_W'(ENTRIES - 1)) begin
          state_d = BP_ST_READY;
          sweep_d = '0;
        end else begin
          sweep_d = sweep_q + IDX_W'(1);
        end
      end
      BP_ST_READY: begin
        if (inv_req) begin
          state_d = BP_ST_INIT;
          sweep_d = '0;
        end
      end
      default: begin
        state_d = BP_ST_INIT;
        sweep_d = '0;
      end
    endcase
  end

  // valid bits: cleared by the sweep, set on allocation
  always_ff @(posedge clk) begin
    if (state_q == BP_ST_INIT) begin
      valid_q[sweep_q] <= 1'b0;
    end else if (wr_en && !u_hit) begin
      valid_q[u_idx] <= 1'b1;
    end
  end

  // entry payload: no reset, guarded by the valid bits
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[u_idx] <= u_tag;
      ctr_q[u_idx] <= u_hit ? ctr_nxt : BP_WT;
      if (upd_taken) tgt_q[u_idx] <= upd_target;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] n_upd_q, n_mis_q;

  // accepted-update and mispredict counters, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_upd_q <= '0;
      n_mis_q <= '0;
    end else if (upd_acc) begin
      if (n_upd_q != '1) n_upd_q <= n_upd_q + 32'd1;
      if ((upd_pred_taken != upd_taken) && (n_mis_q != '1))
        n_mis_q <= n_mis_q + 32'd1;
    end
  end

  assign stat_updates     = n_upd_q;
  assign stat_mispredicts = n_mis_q;

  logic unused_pc;
  assign unused_pc = ^{fetch_pc[1:0], upd_pc[1:0]};
`else
  logic unused_pc;
  assign unused_pc = ^{fetch_pc[1:0], upd_pc[1:0],
                       upd_pred_taken};
`endif

endmodule

// File: tb/tb_branch_target_predictor.sv
// Scoreboard bench for branch_target_predictor.
// Driver pushes expected lookups; a negedge monitor pops and compares.
module tb_branch_target_predictor;

  localparam int N     = 16;
  localparam int IDX_W = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic        inv_req = 1'b0;
  logic        ready;
`ifdef BP_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  always #5 clk = ~clk;

  branch_target_predictor #(.ENTRIES(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .inv_req        (inv_req),
    .ready          (ready)
`ifdef BP_STATS_EN
    ,
    .stat_updates     (stat_updates),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  typedef struct {
    bit          rdy;
    bit          tk;
    logic [31:0] tgt;
    longint      su;
    longint      sm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model: abstract BTB contents plus sweep countdown
  bit          m_valid [N];
  logic [31:0] m_tag   [N];
  logic [31:0] m_tgt   [N];
  int          m_ctr   [N];
  int          busy    = N;
  longint      m_upd   = 0;
  longint      m_mis   = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic start_sweep();
    busy = N;
    for (int i = 0; i < N; i++) m_valid[i] = 1'b0;
  endtask

  task automatic step(input logic [31:0] fpc, input bit uv,
                      input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input bit upt,
                      input bit inv, input bit rn);
    exp_t e;
    int   fi, ui;
    bit   h;
    fetch_pc       = fpc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_pred_taken = upt;
    inv_req        = inv;
    rst_n          = rn;
    if (!rn) begin
      start_sweep();
      m_upd = 0;
      m_mis = 0;
    end
    e.rdy = (busy == 0);
    fi    = int'((fpc >> 2) % N);
    h     = e.rdy && m_valid[fi]
            && (m_tag[fi] == (fpc >> (IDX_W + 2)));
    e.tk  = h && (m_ctr[fi] >= 2);
    e.tgt = e.tk ? m_tgt[fi] : 32'h0;
    e.su  = m_upd;
    e.sm  = m_mis;
    q.push_back(e);
    if (rn) begin
      if (busy != 0) begin
        if (inv) start_sweep();
        else busy--;
      end else if (inv) begin
        start_sweep();
      end else if (uv) begin
        if (m_upd < 64'hFFFF_FFFF) m_upd++;
        if (upt != ut && m_mis < 64'hFFFF_FFFF) m_mis++;
        ui = int'((upc >> 2) % N);
        h  = m_valid[ui]
             && (m_tag[ui] == (upc >> (IDX_W + 2)));
        if (h) begin
          if (ut) begin
            m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
            m_tgt[ui] = utgt;
          end else begin
            m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
          end
        end else if (ut) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = upc >> (IDX_W + 2);
          m_tgt[ui]   = utgt;
          m_ctr[ui]   = 2;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    step(pc, 0, 32'h0, 0, 32'h0, 0, 0, 1);
  endtask

  task automatic upd(input logic [31:0] fpc, input logic [31:0] pc,
                     input bit t, input logic [31:0] tgt,
                     input bit pt);
    step(fpc, 1, pc, t, tgt, pt, 0, 1);
  endtask

  function automatic logic [31:0] rpc();
    logic [31:0] p;
    p = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2)
        | $urandom_range(0, 3);
    return p;
  endfunction

  // monitor: compare DUT outputs with the queued expectation
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ready", 64'(ready), 64'(e.rdy));
      chk("pred_taken", 64'(pred_taken), 64'(e.tk));
      chk("pred_target", 64'(pred_target), 64'(e.tgt));
`ifdef BP_STATS_EN
      chk("stat_updates", 64'(stat_updates), e.su);
      chk("stat_mispredicts", 64'(stat_mispredicts), e.sm);
`endif
    end
  end

  initial begin
    @(posedge clk);
    #1;
    step(rpc(), 0, 0, 0, 0, 0, 0, 0);
    step(rpc(), 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N; i++)
      step(rpc(), 1, rpc(), 1, $urandom, 0, 0, 1);
    upd(32'h100, 32'h100, 1, 32'h200, 0);
    look(32'h100);
    look(32'h104);
    upd(32'h104, 32'h100, 0, 32'h0, 1);
    look(32'h100);
    upd(32'h104, 32'h100, 1, 32'h200, 0);
    look(32'h100);
    upd(32'h104, 32'h140, 1, 32'h300, 1);
    look(32'h100);
    look(32'h140);
    upd(32'h180, 32'h180, 1, 32'h400, 0);
    look(32'h180);
    step(32'h180, 1, 32'h1C0, 1, 32'h500, 0, 1, 1);
    for (int i = 0; i < N; i++)
      look((i % 2) ? 32'h180 : 32'h140);
    look(32'h180);
    look(32'h1C0);
    step(rpc(), 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) look(rpc());
    step(rpc(), 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 4; i++) look(rpc());
    step(rpc(), 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < N + 2; i++)
      step(rpc(), 1, rpc(), 1, $urandom, 1, 0, 1);
    for (int i = 0; i < 900; i++) begin
      bit inv, rn;
      inv = ($urandom_range(0, 99) == 0);
      rn  = ($urandom_range(0, 399) != 0);
      step(rpc(), $urandom_range(0, 1) == 1, rpc(),
           $urandom_range(0, 2) != 0, $urandom,
           $urandom_range(0, 1) == 1, inv, rn);
    end
    @(negedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
